ddr_init_sequencer: RTL and testbench
=====================================

DDR_INIT_SEQUENCER -- requirements
Module: ddr_init_sequencer

Interface
REQ-001 SHALL have parameter FREQ, default 100, user clock frequency in MHz.
REQ-002 SHALL have parameter NUM_CH, default 2, number of DDR channels (1..4).
REQ-003 SHALL have parameter CH_MASK, default all-ones NUM_CH bits, channel enable mask.
REQ-004 SHALL have parameter RST_CYC, default 16, master-reset low cycles (>=1).
REQ-005 SHALL have parameter SEQ_RST_CYC, default 2, sequencer-reset-only cycles (>=1).
REQ-006 SHALL have parameter START_DLY, default 4, cycles from sequencer-reset release to start (>=1).
REQ-007 SHALL have parameter INIT_US, default 1500, calibration timeout in us; timeout cycles TO_CYC = INIT_US*FREQ.
REQ-008 SHALL have parameter MAX_RETRY, default 3, automatic retries after timeout.
REQ-009 clk  in  1  user clock; single clock domain.
REQ-010 rst  in  1  synchronous, active-high reset.
REQ-011 restart_i  in  1  restart request, honoured only in DONE or FAIL.
REQ-012 cal_done_i  in  NUM_CH  per-channel calibration done from DDR controller.
REQ-013 ddr_rstn  out  1  DDR master reset, active low.
REQ-014 ddr_cfg_seq_rst  out  NUM_CH  per-channel sequencer reset, active high.
REQ-015 ddr_cfg_seq_start  out  NUM_CH  per-channel sequencer start, level.
REQ-016 ch_done  out  NUM_CH  sticky per-channel done status.
REQ-017 ddr_init_done  out  1  all enabled channels done.
REQ-018 fail  out  1  retries exhausted.
REQ-019 retry_cnt  out  $clog2(MAX_RETRY+1)  retries consumed since rst/restart.

Function
REQ-020 States: RST_HOLD, SEQ_RST, START_WAIT, CAL_WAIT, DONE, FAIL; one down-counter reloaded on every state entry.
REQ-021 RST_HOLD: ddr_rstn=0, seq_rst=all 1, seq_start=0; exactly RST_CYC cycles, then SEQ_RST.
REQ-022 SEQ_RST: ddr_rstn=1, seq_rst=all 1; exactly SEQ_RST_CYC cycles, then START_WAIT.
REQ-023 START_WAIT: seq_rst=0 on enabled channels; exactly START_DLY cycles, then CAL_WAIT.
REQ-024 CAL_WAIT: seq_start=1 on enabled channels, held until state exit; timeout counter runs TO_CYC cycles.
REQ-025 Disabled channels (CH_MASK bit 0): seq_rst=1 and seq_start=0 always; ch_done bit reads 1 once CAL_WAIT entered.
REQ-026 ch_done[i] set in CAL_WAIT on first cycle cal_done_i[i]=1 (registered, 1-cycle latency); sticky until next RST_HOLD entry; cal_done_i ignored outside CAL_WAIT.
REQ-027 All ch_done=1 -> DONE next cycle; ddr_init_done=1 while in DONE only.
REQ-028 Timeout with retry_cnt<MAX_RETRY -> retry_cnt+1, RST_HOLD; with retry_cnt=MAX_RETRY -> FAIL, fail=1.
REQ-029 Last channel done coincident with timeout expiry: DONE wins, no retry.
REQ-030 restart_i in DONE/FAIL -> RST_HOLD next cycle, retry_cnt=0, fail=0, ddr_init_done=0; ignored in other states.
REQ-031 Counter width $clog2(max(RST_CYC,SEQ_RST_CYC,START_DLY,TO_CYC)+1); TO_CYC computed at elaboration, no runtime multiply.
REQ-032 All outputs registered; no combinational path input->output.

Reset
REQ-033 rst=1 at any cycle, incl. mid-CAL_WAIT -> next state RST_HOLD, ddr_rstn=0, seq_rst=all 1, seq_start=0, ch_done=0, ddr_init_done=0, fail=0, retry_cnt=0, counter=RST_CYC.
REQ-034 rst dominates restart_i and cal_done_i in the same cycle.

Structure
REQ-035 Package ddr_seq_pkg SHALL hold the state enum and the counter-width/TO_CYC helper functions.
REQ-036 One sub-module ddr_seq_timer (loadable down-counter with load value, load, expired flag) SHALL be instantiated once.

Verification (FREQ=1, INIT_US=20, RST_CYC=4, SEQ_RST_CYC=2, START_DLY=3, NUM_CH=2, MAX_RETRY=1)
REQ-037 rst released, cal_done_i=2'b11 at CAL_WAIT cycle 5 -> ddr_rstn low 4 cycles, seq_rst low after 6, seq_start high after 9, ddr_init_done=1 two cycles after cal_done_i.
REQ-038 cal_done_i[0] at cycle 2, [1] at cycle 10 of CAL_WAIT -> ch_done=01 then 11, init_done only after cycle 10.
REQ-039 cal_done_i=0 forever -> timeout at 20 cycles, retry_cnt=1, full sequence repeats, second timeout -> fail=1, state FAIL.
REQ-040 CH_MASK=2'b01, only cal_done_i[0] -> ddr_init_done=1; seq_start[1]=0 and seq_rst[1]=1 throughout.
REQ-041 rst pulsed mid-CAL_WAIT -> next cycle ddr_rstn=0, all status cleared; restart_i during CAL_WAIT -> no effect.
REQ-042 cal_done_i last bit on the expiring cycle -> DONE, retry_cnt unchanged.

Source files
------------

// File: rtl/ddr_seq_pkg.sv
// Shared types and elaboration-time helpers for the DDR init sequencer.
package ddr_seq_pkg;

  typedef enum logic [2:0] {
    ST_RST_HOLD,
    ST_SEQ_RST,
    ST_START_WAIT,
    ST_CAL_WAIT,
    ST_DONE,
    ST_FAIL
  } seq_state_e;

  function automatic int unsigned to_cyc(input int unsigned init_us,
                                         input int unsigned freq_mhz);
    return init_us * freq_mhz;
  endfunction

  // Width that holds the largest value ever loaded into the phase timer.
  function automatic int unsigned cnt_w(input int unsigned a, input int unsigned b,
                                        input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m + 1);
  endfunction

  function automatic int unsigned retry_w(input int unsigned max_retry);
    return (max_retry == 0) ? 1 : $clog2(max_retry + 1);
  endfunction

endpackage

// File: rtl/ddr_seq_timer.sv
// Loadable down-counter; expired_o marks the last cycle of a loaded interval.
module ddr_seq_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expired_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  // Loading N gives N cycles in the phase: N, N-1, ... 1.
  assign expired_o = (count_q == W'(1));

endmodule

// File: rtl/ddr_init_sequencer.sv
// DDR power-up sequencer: master reset, per-channel sequencer reset/start,
// calibration wait with timeout and bounded automatic retry.
module ddr_init_sequencer
  import ddr_seq_pkg::*;
#(
  parameter int unsigned       FREQ        = 100,
  parameter int unsigned       NUM_CH      = 2,
  parameter logic [NUM_CH-1:0] CH_MASK     = '1,
  parameter int unsigned       RST_CYC     = 16,
  parameter int unsigned       SEQ_RST_CYC = 2,
  parameter int unsigned       START_DLY   = 4,
  parameter int unsigned       INIT_US     = 1500,
  parameter int unsigned       MAX_RETRY   = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             restart_i,
  input  logic [NUM_CH-1:0]                cal_done_i,
  output logic                             ddr_rstn,
  output logic [NUM_CH-1:0]                ddr_cfg_seq_rst,
  output logic [NUM_CH-1:0]                ddr_cfg_seq_start,
  output logic [NUM_CH-1:0]                ch_done,
  output logic                             ddr_init_done,
  output logic                             fail,
  output logic [retry_w(MAX_RETRY)-1:0]    retry_cnt
);

  localparam int unsigned TO_CYC = to_cyc(INIT_US, FREQ);
  localparam int unsigned CW     = cnt_w(RST_CYC, SEQ_RST_CYC, START_DLY, TO_CYC);
  localparam int unsigned RW     = retry_w(MAX_RETRY);
  localparam logic [NUM_CH-1:0] ALL_CH = '1;

  seq_state_e        state_q, state_d;
  logic              rstn_q, rstn_d;
  logic [NUM_CH-1:0] seq_rst_q, seq_rst_d;
  logic [NUM_CH-1:0] seq_start_q, seq_start_d;
  logic [NUM_CH-1:0] ch_done_q, ch_done_d;
  logic              init_done_q, init_done_d;
  logic              fail_q, fail_d;
  logic [RW-1:0]     retry_q, retry_d;
  logic [NUM_CH-1:0] cal_acc;
  logic              tmr_load, tmr_expired;
  logic [CW-1:0]     tmr_val;

  ddr_seq_timer #(.W(CW)) u_timer (
    .clk        (clk),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expired_o  (tmr_expired)
  );

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    cal_acc = ch_done_q | (cal_done_i & CH_MASK);
    unique case (state_q)
      ST_RST_HOLD:   if (tmr_expired) state_d = ST_SEQ_RST;
      ST_SEQ_RST:    if (tmr_expired) state_d = ST_START_WAIT;
      ST_START_WAIT: if (tmr_expired) state_d = ST_CAL_WAIT;
      ST_CAL_WAIT: begin
        // A channel finishing on the expiring cycle beats the timeout.
        if (ch_done_q == ALL_CH) begin
          state_d = ST_DONE;
        end else if (tmr_expired) begin
          if (cal_acc == ALL_CH) begin
            state_d = ST_DONE;
          end else if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + RW'(1);
            state_d = ST_RST_HOLD;
          end else begin
            state_d = ST_FAIL;
          end
        end
      end
      ST_DONE, ST_FAIL: begin
        if (restart_i) begin
          state_d = ST_RST_HOLD;
          retry_d = '0;
        end
      end
      default: state_d = ST_RST_HOLD;
    endcase
  end

  always_comb begin
    ch_done_d = ch_done_q;
    if (state_d == ST_RST_HOLD) begin
      ch_done_d = '0;
    end else if (state_q == ST_CAL_WAIT) begin
      ch_done_d = cal_acc;
    end else if (state_d == ST_CAL_WAIT) begin
      ch_done_d = ~CH_MASK;
    end

    rstn_d      = 1'b1;
    seq_rst_d   = ~CH_MASK;
    seq_start_d = '0;
    unique case (state_d)
      ST_RST_HOLD: begin
        rstn_d    = 1'b0;
        seq_rst_d = '1;
      end
      ST_SEQ_RST:  seq_rst_d   = '1;
      ST_CAL_WAIT: seq_start_d = CH_MASK;
      default: ;
    endcase
    init_done_d = (state_d == ST_DONE);
    fail_d      = (state_d == ST_FAIL);
  end

  always_comb begin
    tmr_load = rst | (state_d != state_q);
    unique case (state_d)
      ST_RST_HOLD:   tmr_val = CW'(RST_CYC);
      ST_SEQ_RST:    tmr_val = CW'(SEQ_RST_CYC);
      ST_START_WAIT: tmr_val = CW'(START_DLY);
      ST_CAL_WAIT:   tmr_val = CW'(TO_CYC);
      default:       tmr_val = '0;
    endcase
    if (rst) tmr_val = CW'(RST_CYC);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RST_HOLD;
      rstn_q      <= 1'b0;
      seq_rst_q   <= '1;
      seq_start_q <= '0;
      ch_done_q   <= '0;
      init_done_q <= 1'b0;
      fail_q      <= 1'b0;
      retry_q     <= '0;
    end else begin
      state_q     <= state_d;
      rstn_q      <= rstn_d;
      seq_rst_q   <= seq_rst_d;
      seq_start_q <= seq_start_d;
      ch_done_q   <= ch_done_d;
      init_done_q <= init_done_d;
      fail_q      <= fail_d;
      retry_q     <= retry_d;
    end
  end

  assign ddr_rstn          = rstn_q;
  assign ddr_cfg_seq_rst   = seq_rst_q;
  assign ddr_cfg_seq_start = seq_start_q;
  assign ch_done           = ch_done_q;
  assign ddr_init_done     = init_done_q;
  assign fail              = fail_q;
  assign retry_cnt         = retry_q;

endmodule

// File: tb/tb_ddr_init_sequencer.sv
// Bench for ddr_init_sequencer: two instances (both channels enabled, and
// channel 1 masked off) checked every cycle against a timeline model.
module tb_ddr_init_sequencer;

  localparam int T_SR  = 4;          // RST_HOLD length
  localparam int T_SW  = 6;          // START_WAIT begins
  localparam int T_CAL = 9;          // CAL_WAIT begins
  localparam int TO    = 20;         // INIT_US * FREQ
  localparam int MAXR  = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       restart = 1'b0;
  logic [1:0] cal_a = 2'b00, cal_b = 2'b00;

  logic       rstn_a, rstn_b, idone_a, idone_b, fail_a, fail_b;
  logic [1:0] srst_a, srst_b, start_a, start_b, chd_a, chd_b;
  logic [0:0] retry_a, retry_b;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ddr_init_sequencer #(.FREQ(1), .NUM_CH(2), .CH_MASK(2'b11), .RST_CYC(4),
    .SEQ_RST_CYC(2), .START_DLY(3), .INIT_US(20), .MAX_RETRY(1)) dut_a (
    .clk(clk), .rst(rst), .restart_i(restart), .cal_done_i(cal_a),
    .ddr_rstn(rstn_a), .ddr_cfg_seq_rst(srst_a), .ddr_cfg_seq_start(start_a),
    .ch_done(chd_a), .ddr_init_done(idone_a), .fail(fail_a), .retry_cnt(retry_a));

  ddr_init_sequencer #(.FREQ(1), .NUM_CH(2), .CH_MASK(2'b01), .RST_CYC(4),
    .SEQ_RST_CYC(2), .START_DLY(3), .INIT_US(20), .MAX_RETRY(1)) dut_b (
    .clk(clk), .rst(rst), .restart_i(restart), .cal_done_i(cal_b),
    .ddr_rstn(rstn_b), .ddr_cfg_seq_rst(srst_b), .ddr_cfg_seq_start(start_b),
    .ch_done(chd_b), .ddr_init_done(idone_b), .fail(fail_b), .retry_cnt(retry_b));

  task automatic chk(input string nm, input int k, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d @%0t: got %0h expected %0h", nm, k, $time, act, exp);
    end
  endtask

  // Model: t counts cycles since the current attempt's first RST_HOLD cycle.
  int         m_t[2], m_retry[2];
  bit         m_done[2], m_fail[2], m_valid = 1'b0;
  logic [1:0] m_chd[2];

  function automatic logic [1:0] msk(input int k);
    return (k == 0) ? 2'b11 : 2'b01;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [1:0] cal, nchd;
      cal = (k == 0) ? cal_a : cal_b;
      if (rst || ((m_done[k] || m_fail[k]) && restart)) begin
        m_t[k] = 0; m_retry[k] = 0; m_done[k] = 0; m_fail[k] = 0; m_chd[k] = 2'b00;
      end else if (!m_done[k] && !m_fail[k]) begin
        if (m_t[k] >= T_CAL) begin
          nchd = m_chd[k] | (cal & msk(k));
          if (m_chd[k] == 2'b11) begin
            m_done[k] = 1;
          end else if (m_t[k] - T_CAL == TO - 1) begin
            if (nchd == 2'b11) begin
              m_done[k] = 1; m_chd[k] = nchd;
            end else if (m_retry[k] < MAXR) begin
              m_retry[k]++; m_t[k] = 0; m_chd[k] = 2'b00;
            end else begin
              m_fail[k] = 1; m_chd[k] = nchd;
            end
          end else begin
            m_chd[k] = nchd; m_t[k]++;
          end
        end else begin
          m_t[k]++;
          if (m_t[k] == T_CAL) m_chd[k] = ~msk(k);
        end
      end
    end
    if (rst) m_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      for (int k = 0; k < 2; k++) begin
        logic e_rstn;
        logic [1:0] e_srst, e_start;
        e_rstn = 1'b1; e_srst = ~msk(k); e_start = 2'b00;
        if (!m_done[k] && !m_fail[k]) begin
          if (m_t[k] < T_SR) begin e_rstn = 1'b0; e_srst = 2'b11; end
          else if (m_t[k] < T_SW) e_srst = 2'b11;
          else if (m_t[k] >= T_CAL) e_start = msk(k);
        end
        chk("ddr_rstn",  k, 8'(k == 0 ? rstn_a : rstn_b),   8'(e_rstn));
        chk("seq_rst",   k, 8'(k == 0 ? srst_a : srst_b),   8'(e_srst));
        chk("seq_start", k, 8'(k == 0 ? start_a : start_b), 8'(e_start));
        chk("ch_done",   k, 8'(k == 0 ? chd_a : chd_b),     8'(m_chd[k]));
        chk("init_done", k, 8'(k == 0 ? idone_a : idone_b), 8'(m_done[k]));
        chk("fail",      k, 8'(k == 0 ? fail_a : fail_b),   8'(m_fail[k]));
        chk("retry_cnt", k, 8'(k == 0 ? retry_a : retry_b), 8'(m_retry[k]));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; restart = 1'b0; cal_a = 2'b00; cal_b = 2'b00;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    // Nominal bring-up, both instances; labels below are cycles since release.
    do_reset();
    chk("lit_rstn_t0", 0, 8'(rstn_a), 8'h0);
    chk("lit_srst_t0", 0, 8'(srst_a), 8'h3);
    tick(3);  chk("lit_rstn_t3", 0, 8'(rstn_a), 8'h0);
    tick(1);  chk("lit_rstn_t4", 0, 8'(rstn_a), 8'h1);
              chk("lit_srst_t4", 0, 8'(srst_a), 8'h3);
    tick(2);  chk("lit_srst_t6", 0, 8'(srst_a), 8'h0);
              chk("lit_srst_t6", 1, 8'(srst_b), 8'h2);
    tick(2);  chk("lit_start_t8", 0, 8'(start_a), 8'h0);
    tick(1);  chk("lit_start_t9", 0, 8'(start_a), 8'h3);
              chk("lit_start_t9", 1, 8'(start_b), 8'h1);
              chk("lit_chd_t9", 1, 8'(chd_b), 8'h2);
    tick(4);  cal_a = 2'b11; cal_b = 2'b01;
    tick(1);  cal_a = 2'b00; cal_b = 2'b00;
              chk("lit_chd_t14", 0, 8'(chd_a), 8'h3);
              chk("lit_idone_t14", 0, 8'(idone_a), 8'h0);
    tick(1);  chk("lit_idone_t15", 0, 8'(idone_a), 8'h1);
              chk("lit_idone_t15", 1, 8'(idone_b), 8'h1);
              chk("lit_start_t15", 0, 8'(start_a), 8'h0);

    // Restart from DONE; staggered channel completion; restart ignored in CAL_WAIT.
    restart = 1'b1;
    tick(1);  restart = 1'b0;
              chk("lit_restart_rstn", 0, 8'(rstn_a), 8'h0);
              chk("lit_restart_idone", 0, 8'(idone_a), 8'h0);
    tick(10); cal_a = 2'b01;
    tick(1);  cal_a = 2'b00;
              chk("lit_chd_01", 0, 8'(chd_a), 8'h1);
              restart = 1'b1;
    tick(1);  restart = 1'b0;
              chk("lit_restart_ignored", 0, 8'(start_a), 8'h3);
    tick(6);  cal_a = 2'b10;
              chk("lit_idone_t18", 0, 8'(idone_a), 8'h0);
    tick(1);  cal_a = 2'b00;
              chk("lit_chd_11", 0, 8'(chd_a), 8'h3);
              chk("lit_idone_t19", 0, 8'(idone_a), 8'h0);
    tick(1);  chk("lit_idone_t20", 0, 8'(idone_a), 8'h1);

    // Reset mid-CAL_WAIT, colliding with restart and cal_done.
    do_reset();
    tick(10); cal_a = 2'b01;
    tick(1);  cal_a = 2'b00;
    tick(1);  rst = 1'b1; restart = 1'b1; cal_a = 2'b11; cal_b = 2'b11;
    tick(1);  rst = 1'b0; restart = 1'b0; cal_a = 2'b00; cal_b = 2'b00;
              chk("lit_midrst_rstn", 0, 8'(rstn_a), 8'h0);
              chk("lit_midrst_chd", 0, 8'(chd_a), 8'h0);
              chk("lit_midrst_start", 0, 8'(start_a), 8'h0);

    // No calibration: one retry, then FAIL; then restart out of FAIL.
    tick(28); chk("lit_retry_t28", 0, 8'(retry_a), 8'h0);
              chk("lit_start_t28", 0, 8'(start_a), 8'h3);
    tick(1);  chk("lit_retry_t29", 0, 8'(retry_a), 8'h1);
              chk("lit_rstn_t29", 0, 8'(rstn_a), 8'h0);
    tick(28); chk("lit_fail_t57", 0, 8'(fail_a), 8'h0);
    tick(1);  chk("lit_fail_t58", 0, 8'(fail_a), 8'h1);
              chk("lit_fail_t58", 1, 8'(fail_b), 8'h1);
              chk("lit_retry_t58", 0, 8'(retry_a), 8'h1);
    tick(3);  chk("lit_fail_hold", 0, 8'(fail_a), 8'h1);
    restart = 1'b1;
    tick(1);  restart = 1'b0;
              chk("lit_fail_clr", 0, 8'(fail_a), 8'h0);
              chk("lit_retry_clr", 0, 8'(retry_a), 8'h0);

    // Last channel completes on the expiring cycle: DONE, no retry.
    tick(10); cal_a = 2'b01;
    tick(1);  cal_a = 2'b00;
    tick(17); cal_a = 2'b10; cal_b = 2'b01;
              chk("lit_edge_idone", 0, 8'(idone_a), 8'h0);
    tick(1);  cal_a = 2'b00; cal_b = 2'b00;
              chk("lit_edge_idone", 0, 8'(idone_a), 8'h1);
              chk("lit_edge_idone", 1, 8'(idone_b), 8'h1);
              chk("lit_edge_retry", 0, 8'(retry_a), 8'h0);
              chk("lit_edge_rstn", 0, 8'(rstn_a), 8'h1);
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
